cla_seq_adder: RTL and testbench

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

---
 rtl/cla_seq_adder.sv | 168 ++++++++++++++++
 tb/tb_cla_seq_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - multi-cycle adder, one carry-lookahead group per cycle
// Optional feature macro: CLA_SEQ_ADDER_SUB_EN (adds the sub input for a - b)
module cla_seq_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = (GROUP > 0) ? (WIDTH / GROUP) : 1;
    localparam int KW = (NG > 1) ? $clog2(NG) : 1;

    // Reject geometries where the groups do not tile the operand exactly
    generate
        if (GROUP <= 0 || WIDTH <= 0 || (WIDTH % GROUP) != 0) begin : g_bad_geometry
            $error("cla_seq_adder: WIDTH must be a non-zero multiple of GROUP");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [GROUP-1:0]  grp_p, grp_g, grp_s;
    logic [GROUP:0]    grp_c;
    logic              term;
    logic              last_group;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign sum        = sum_q;
    assign cout       = cout_q;
    assign ovf        = ovf_q;
    assign last_group = (k_q == KW'(NG - 1));

    // Operand B and carry-in as seen by the adder (subtract folds into ~b + 1)
    always_comb begin
        b_eff   = b;
        cin_eff = cin;
`ifdef CLA_SEQ_ADDER_SUB_EN
        if (sub) begin
            b_eff   = ~b;
            cin_eff = 1'b1;
        end
`endif
    end

    // Flattened lookahead for the group selected by k: every carry is a sum of products
    always_comb begin
        grp_p = a_q[k_q*GROUP +: GROUP] ^ b_q[k_q*GROUP +: GROUP];
        grp_g = a_q[k_q*GROUP +: GROUP] & b_q[k_q*GROUP +: GROUP];
        grp_c = '0;
        term  = 1'b0;
        grp_c[0] = carry_q;
        for (int i = 1; i <= GROUP; i++) begin
            term = carry_q;
            for (int m = 0; m < i; m++) begin
                term = term & grp_p[m];
            end
            grp_c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & grp_p[m];
                end
                grp_c[i] = grp_c[i] | term;
            end
        end
        grp_s = grp_p ^ grp_c[GROUP-1:0];
    end

    // Next-state logic: accept, step through groups, hold the result until consumed
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    k_d     = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d[k_q*GROUP +: GROUP] = grp_s;
                carry_d = grp_c[GROUP];
                if (last_group) begin
                    cout_d  = grp_c[GROUP];
                    ovf_d   = grp_c[GROUP-1] ^ grp_c[GROUP];
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous abort on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - directed vector bench for cla_seq_adder (WIDTH=16, GROUP=4)
module tb_cla_seq_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks;
    int errors;

    cla_seq_adder #(.WIDTH(16), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present operands at a falling edge, wait for the result, check it, then consume it
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"},  32'(sum),  32'(v.sum));
        check({tag, "_cout"}, 32'(cout), 32'(v.cout));
        check({tag, "_ovf"},  32'(ovf),  32'(v.ovf));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_after"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        vec_t v;
        logic [15:0] held_sum;
        logic        held_cout;
        logic        held_ovf;
        int          lat;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
        vecs.push_back('{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
`ifdef CLA_SEQ_ADDER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

        #12;
        check("reset_outputs", 32'({out_valid, in_ready, cout, ovf}), 32'b0100);
        check("reset_sum", 32'(sum), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Held result in DONE while new operands are offered (also offered during BUSY)
        v = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        a = v.a; b = v.b; cin = v.cin; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("hold_latency", 32'(lat), 32'd4);
        check("hold_sum0", 32'(sum), 32'h5556);
        held_sum  = sum;
        held_cout = cout;
        held_ovf  = ovf;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold_sum_c%0d", c), 32'(sum), 32'(held_sum));
            check($sformatf("hold_flags_c%0d", c), 32'({cout, ovf}), 32'({held_cout, held_ovf}));
            check($sformatf("hold_hs_c%0d", c), 32'({out_valid, in_ready}), 32'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("hold_release_idle", 32'({out_valid, in_ready}), 32'b01);
        @(posedge clk);
        @(negedge clk);
        check("hold_no_capture", 32'({out_valid, in_ready}), 32'b01);

        // Reset in the middle of BUSY aborts the operation
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort_partial_sum", 32'(sum), 32'h00FE);
        check("abort_busy_hs", 32'({out_valid, in_ready}), 32'b00);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({out_valid, in_ready, cout, ovf}), 32'b0100);
        check("abort_sum", 32'(sum), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0}, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
